// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice is reused LSB-first over WIDTH cycles.
// The slice is composed from the shared xor_gate/and_gate/or_gate cells.

module xor_gate (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i ^ b_i;
endmodule

module and_gate (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i & b_i;
endmodule

module or_gate (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i | b_i;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic halfSum;
    logic bitSum;
    logic genBit;
    logic propBit;
    logic carryNext;

    // Full-adder slice on the current LSBs and the carry flop.
    xor_gate uHalfSum (.a_i(opA_q[0]), .b_i(opB_q[0]), .y_o(halfSum));
    xor_gate uBitSum  (.a_i(halfSum),  .b_i(carry_q),  .y_o(bitSum));
    and_gate uGen     (.a_i(opA_q[0]), .b_i(opB_q[0]), .y_o(genBit));
    and_gate uProp    (.a_i(carry_q),  .b_i(halfSum),  .y_o(propBit));
    or_gate  uCarry   (.a_i(genBit),   .b_i(propBit),  .y_o(carryNext));

    always_comb begin
        state_d = state_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    opA_d   = a;
                    opB_d   = b;
                    res_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                opA_d   = {1'b0, opA_q[WIDTH-1:1]};
                opB_d   = {1'b0, opB_q[WIDTH-1:1]};
                res_d   = {bitSum, res_q[WIDTH-1:1]};
                carry_d = carryNext;
                cnt_d   = cnt_q + CW'(1);
                // The final bit lands in the result MSB on the same edge sum is published.
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    sum_d   = {bitSum, res_q[WIDTH-1:1]};
                    cout_d  = carryNext;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opA_q   <= '0;
            opB_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit instance checked cycle by cycle against a timing model
// and scoreboard, plus a 4-bit instance swept over every operand pair.

module tb_serial_adder;

    typedef struct {
        logic [8:0] val;
        int         due;
    } entry8_t;

    logic       clk;
    logic       rst;
    logic       start8;
    logic [7:0] a8, b8, sum8;
    logic       busy8, done8, cout8;
    logic       start4;
    logic [3:0] a4, b4, sum4;
    logic       busy4, done4, cout4;

    int total;
    int bad;
    int cyc;

    entry8_t    exp8[$];
    logic [4:0] exp4[$];

    logic [1:0] mState;
    int         mCnt;
    logic [8:0] mHeld;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [32:0] observed, input logic [32:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, observed, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference timing model of the 8-bit instance; pushes the expected result at each accepted start.
    always @(posedge clk) begin
        entry8_t e;
        cyc++;
        if (rst) begin
            mState = 2'd0;
            mCnt   = 0;
            mHeld  = '0;
            exp8.delete();
        end else begin
            case (mState)
                2'd0: if (start8) begin
                    e.val = {1'b0, a8} + {1'b0, b8};
                    e.due = cyc + 8;
                    exp8.push_back(e);
                    mState = 2'd1;
                    mCnt   = 0;
                end
                2'd1: begin
                    mCnt++;
                    if (mCnt == 8) begin
                        mState = 2'd2;
                        if (exp8.size() > 0) mHeld = exp8[0].val;
                    end
                end
                default: mState = 2'd0;
            endcase
        end
    end

    // Sampled on the falling edge, away from the state-changing edge.
    always @(negedge clk) begin
        entry8_t e;
        logic [4:0] e4;
        checkOutput("busy8", {32'd0, busy8}, rst ? 33'd0 : {32'd0, mState == 2'd1});
        checkOutput("done8", {32'd0, done8}, rst ? 33'd0 : {32'd0, mState == 2'd2});
        checkOutput("held8", {24'd0, cout8, sum8}, rst ? 33'd0 : {24'd0, mHeld});
        if (done8) begin
            if (exp8.size() == 0) begin
                checkOutput("extraDone8", {32'd0, done8}, 33'd0);
            end else begin
                e = exp8.pop_front();
                checkOutput("sum8", {24'd0, cout8, sum8}, {24'd0, e.val});
                checkOutput("latency8", 33'(cyc), 33'(e.due));
            end
        end
        if (done4) begin
            if (exp4.size() == 0) begin
                checkOutput("extraDone4", {32'd0, done4}, 33'd0);
            end else begin
                e4 = exp4.pop_front();
                checkOutput("sum4", {28'd0, cout4, sum4}, {28'd0, e4});
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y);
        tick();
        a8     = x;
        b8     = y;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
    endtask

    task automatic waitIdle();
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mState == 2'd0 && exp8.size() == 0) begin
                idle = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("idleTimeout", {32'd0, idle}, 33'd1);
    endtask

    initial begin
        logic drained;
        total  = 0;
        bad    = 0;
        cyc    = 0;
        mState = 2'd0;
        mCnt   = 0;
        mHeld  = '0;
        rst    = 1'b1;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        start4 = 1'b0;
        a4     = '0;
        b4     = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        applyStimulus(8'd3, 8'd5);
        waitIdle();
        applyStimulus(8'd255, 8'd1);
        waitIdle();
        applyStimulus(8'd200, 8'd100);
        waitIdle();
        applyStimulus(8'd0, 8'd0);
        waitIdle();

        // A second start while busy must be ignored.
        applyStimulus(8'd3, 8'd5);
        tick();
        a8     = 8'd1;
        b8     = 8'd1;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        waitIdle();

        // Asynchronous abort in the middle of a shift.
        applyStimulus(8'd255, 8'd1);
        tick();
        tick();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstBusy", {32'd0, busy8}, 33'd0);
        checkOutput("rstSum", {24'd0, cout8, sum8}, 33'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        applyStimulus(8'd7, 8'd9);
        waitIdle();

        // Start coincident with a reset edge is dropped.
        tick();
        rst    = 1'b1;
        a8     = 8'd9;
        b8     = 8'd9;
        start8 = 1'b1;
        tick();
        rst    = 1'b0;
        start8 = 1'b0;
        tick();
        tick();
        waitIdle();

        // Start held high with operands changing every cycle.
        for (int n = 0; n < 40; n++) begin
            tick();
            a8     = 8'($urandom);
            b8     = 8'($urandom);
            start8 = 1'b1;
        end
        tick();
        start8 = 1'b0;
        waitIdle();

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                tick();
                a4     = 4'(i);
                b4     = 4'(j);
                start4 = 1'b1;
                exp4.push_back(5'(i + j));
                tick();
                start4 = 1'b0;
                for (int k = 0; k < 12; k++) begin
                    if (exp4.size() == 0) break;
                    tick();
                end
            end
        end
        tick();
        tick();
        drained = (exp4.size() == 0);
        checkOutput("drain4", {32'd0, drained}, 33'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to add a and b; sampled on rising edge of clk.
REQ-005 a  input  WIDTH  operand A; sampled only on the edge where start is accepted.
REQ-006 b  input  WIDTH  operand B; sampled only on the edge where start is accepted.
REQ-007 busy  output  1  high while an addition is in progress.
REQ-008 done  output  1  one-cycle pulse: sum/cout valid.
REQ-009 sum  output  WIDTH  registered result, (a+b) mod 2^WIDTH.
REQ-010 cout  output  1  registered carry out of the MSB.

Function
REQ-011 The block SHALL be a three-state FSM with states IDLE, SHIFT and DONE.
REQ-012 IDLE -> SHIFT SHALL occur on a clk edge with start=1; that edge loads a and b into internal shift registers, clears the carry flop and clears the bit counter.
REQ-013 In SHIFT, each edge SHALL process one bit, LSB first:
- s = a0 ^ b0 ^ c; c_next = (a0 & b0) | (c & (a0 ^ b0)).
- Operand registers shift right.
- s shifts into the MSB of an internal result register.
- The counter increments.
REQ-014 The per-bit logic SHALL be built from the team's gate-level xor_gate, and_gate and or_gate cells; no behavioural + operator.
REQ-015 SHIFT -> DONE SHALL occur on the edge that processes bit WIDTH-1; that same edge loads sum from the result register and cout from c_next.
REQ-016 DONE -> IDLE SHALL occur unconditionally on the next edge.
REQ-017 Latency: with start accepted at edge t0, done SHALL be high for exactly the cycle between edges t0+WIDTH and t0+WIDTH+1.
REQ-018 busy SHALL be 1 exactly while in SHIFT; done SHALL be 1 exactly while in DONE; busy and done SHALL never both be 1.
REQ-019 start SHALL be ignored in SHIFT and DONE; a, b, sum and cout SHALL be unaffected by it.
REQ-020 sum and cout SHALL hold their last value from DONE until the next completion, through IDLE and the following SHIFT.
REQ-021 Back-to-back operation: start held high continuously SHALL give one accepted operation every WIDTH+2 cycles.
REQ-022 Overflow SHALL wrap modulo 2^WIDTH, with the lost bit reported on cout; there is no error flag.
REQ-023 Changes on a or b after the accepting edge SHALL NOT affect the result in progress.

Reset
REQ-024 While rst=1, regardless of clk:
- State SHALL be IDLE.
- busy, done, sum, cout, carry, counter and shift registers SHALL be 0.
REQ-025 rst asserted mid-SHIFT SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL begin a fresh addition.
REQ-026 A start coincident with the edge on which rst is high SHALL be ignored.

Verification
REQ-027 WIDTH=8, a=3, b=5, start pulse at t0 -> busy for 8 cycles, done at t0+8, sum=8, cout=0.
REQ-028 a=255, b=1 -> sum=0, cout=1; a=200, b=100 -> sum=44, cout=1; a=0, b=0 -> sum=0, cout=0.
REQ-029 start re-pulsed with a=1, b=1 during busy of a 3+5 operation -> ignored; result sum=8; a single done pulse.
REQ-030 rst pulsed at t0+4 of a 255+1 operation -> busy=0 and sum=0 immediately (asynchronous); no done; next start with 7+9 -> sum=16, cout=0.
REQ-031 start held high with operands changed each cycle -> done every 10 cycles; each sum matches the operands present at its accepting edge.
REQ-032 Exhaustive check at WIDTH=4: all 256 a/b pairs -> {cout,sum} equals a+b for every pair.
